// File: rtl/alu_share_arbiter_pkg.sv
// Shared definitions for the ALU sharing arbiter: op encodings, widths and op legality.
package alu_share_arbiter_pkg;

    localparam int unsigned OP_WIDTH     = 3;
    localparam int unsigned WORD_LEN_DEF = 32;

    typedef enum logic [OP_WIDTH-1:0] {
        ADD = 3'd0,
        SUB = 3'd1,
        AND = 3'd2,
        OR  = 3'd3
    } alu_op_e;

    function automatic logic is_legal_op(input logic [OP_WIDTH-1:0] op);
        return op < OP_WIDTH'(4);
    endfunction

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Requester-side bundle: packed per-requester request fields and the shared response.
interface alu_share_arbiter_if
    import alu_share_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned WORD_LEN = WORD_LEN_DEF
);
    logic [NUM_REQ-1:0]          req_valid;
    logic [NUM_REQ-1:0]          req_lock;
    logic [NUM_REQ*WORD_LEN-1:0] req_in1;
    logic [NUM_REQ*WORD_LEN-1:0] req_in2;
    logic [NUM_REQ*OP_WIDTH-1:0] req_op;
    logic [NUM_REQ-1:0]          req_ready;

    logic [NUM_REQ-1:0]          rsp_valid;
    logic [WORD_LEN-1:0]         rsp_result;
    logic                        rsp_zero;
    logic                        rsp_neg;
    logic                        rsp_lt;
    logic                        rsp_err;

    modport master (
        output req_valid, req_lock, req_in1, req_in2, req_op,
        input  req_ready, rsp_valid, rsp_result, rsp_zero, rsp_neg, rsp_lt, rsp_err
    );

    modport slave (
        input  req_valid, req_lock, req_in1, req_in2, req_op,
        output req_ready, rsp_valid, rsp_result, rsp_zero, rsp_neg, rsp_lt, rsp_err
    );
endinterface

// File: rtl/alu_share_arbiter_rr_pick.sv
// Combinational round-robin picker: first valid requester at or above ptr, wrapping to 0.
module rr_pick #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic               found
);

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        // Upper segment [ptr..NUM_REQ-1] first, then the wrapped segment from 0.
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!found && valid[i] && (i >= 32'(ptr))) begin
                gnt[i] = 1'b1;
                found  = 1'b1;
            end
        end
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!found && valid[i]) begin
                gnt[i] = 1'b1;
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one external ALU among NUM_REQ requesters: round-robin with bounded lock,
// combinational grant/operand mux and a one-cycle registered response.
module alu_share_arbiter
    import alu_share_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned WORD_LEN = WORD_LEN_DEF,
    parameter int unsigned LOCK_MAX = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    alu_share_arbiter_if.slave   bus,
    output logic [WORD_LEN-1:0]  alu_in1,
    output logic [WORD_LEN-1:0]  alu_in2,
    output logic [OP_WIDTH-1:0]  alu_op,
    input  logic [WORD_LEN-1:0]  alu_result,
    input  logic                 alu_zero,
    input  logic                 alu_neg,
    input  logic                 alu_lt
);

    localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CNT_W = $clog2(LOCK_MAX + 1);

    logic [PTR_W-1:0]    rr_ptr;
    logic [PTR_W-1:0]    lock_owner;
    logic                lock_active;
    logic [CNT_W-1:0]    lock_cnt;

    logic [NUM_REQ-1:0]  pick_gnt;
    logic                pick_found;
    logic [NUM_REQ-1:0]  owner_onehot;
    logic                locked_path;
    logic [NUM_REQ-1:0]  gnt;
    logic                any_gnt;
    logic [PTR_W-1:0]    gnt_idx;
    logic [WORD_LEN-1:0] sel_in1;
    logic [WORD_LEN-1:0] sel_in2;
    logic [OP_WIDTH-1:0] sel_op;
    logic                gnt_legal;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_pick (
        .valid (bus.req_valid),
        .ptr   (rr_ptr),
        .gnt   (pick_gnt),
        .found (pick_found)
    );

    always_comb begin
        owner_onehot = NUM_REQ'(1) << lock_owner;
        locked_path  = lock_active && (|(bus.req_valid & owner_onehot))
                       && (lock_cnt < CNT_W'(LOCK_MAX));
        gnt          = locked_path ? owner_onehot : pick_gnt;
        any_gnt      = locked_path || pick_found;

        gnt_idx = '0;
        sel_in1 = '0;
        sel_in2 = '0;
        sel_op  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                gnt_idx = PTR_W'(i);
                sel_in1 = bus.req_in1[i*WORD_LEN +: WORD_LEN];
                sel_in2 = bus.req_in2[i*WORD_LEN +: WORD_LEN];
                sel_op  = bus.req_op[i*OP_WIDTH +: OP_WIDTH];
            end
        end
        gnt_legal = is_legal_op(sel_op);

        bus.req_ready = gnt;
        // Illegal ops still consume a grant but present a harmless ADD 0,0 to the ALU.
        alu_in1 = (any_gnt && gnt_legal) ? sel_in1 : '0;
        alu_in2 = (any_gnt && gnt_legal) ? sel_in2 : '0;
        alu_op  = (any_gnt && gnt_legal) ? sel_op  : '0;
    end

    // A grant won through normal arbitration restarts the count at 1, which also
    // covers the forced-release cycle once the count has reached LOCK_MAX.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr      <= '0;
            lock_active <= 1'b0;
            lock_owner  <= '0;
            lock_cnt    <= '0;
        end else if (any_gnt) begin
            rr_ptr <= (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + PTR_W'(1);
            if (|(bus.req_lock & gnt)) begin
                lock_active <= 1'b1;
                lock_owner  <= gnt_idx;
                lock_cnt    <= locked_path ? lock_cnt + CNT_W'(1) : CNT_W'(1);
            end else begin
                lock_active <= 1'b0;
                lock_owner  <= '0;
                lock_cnt    <= '0;
            end
        end else begin
            lock_active <= 1'b0;
            lock_owner  <= '0;
            lock_cnt    <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.rsp_valid  <= '0;
            bus.rsp_result <= '0;
            bus.rsp_zero   <= 1'b0;
            bus.rsp_neg    <= 1'b0;
            bus.rsp_lt     <= 1'b0;
            bus.rsp_err    <= 1'b0;
        end else begin
            bus.rsp_valid <= any_gnt ? gnt : '0;
            if (any_gnt) begin
                if (gnt_legal) begin
                    bus.rsp_result <= alu_result;
                    bus.rsp_zero   <= alu_zero;
                    bus.rsp_neg    <= alu_neg;
                    bus.rsp_lt     <= alu_lt;
                    bus.rsp_err    <= 1'b0;
                end else begin
                    bus.rsp_result <= '0;
                    bus.rsp_zero   <= 1'b0;
                    bus.rsp_neg    <= 1'b0;
                    bus.rsp_lt     <= 1'b0;
                    bus.rsp_err    <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed-vector bench for alu_share_arbiter with a behavioural ALU on the shared port.
module tb_alu_share_arbiter;
    import alu_share_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] alu_in1, alu_in2, alu_result;
    logic [2:0]  alu_op;
    logic        alu_zero, alu_neg, alu_lt;

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    always #5 clk = ~clk;

    alu_share_arbiter_if #(.NUM_REQ(4), .WORD_LEN(32)) bus ();

    alu_share_arbiter #(
        .NUM_REQ  (4),
        .WORD_LEN (32),
        .LOCK_MAX (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .alu_in1    (alu_in1),
        .alu_in2    (alu_in2),
        .alu_op     (alu_op),
        .alu_result (alu_result),
        .alu_zero   (alu_zero),
        .alu_neg    (alu_neg),
        .alu_lt     (alu_lt)
    );

    always_comb begin
        case (alu_op)
            3'd0:    alu_result = alu_in1 + alu_in2;
            3'd1:    alu_result = alu_in1 - alu_in2;
            3'd2:    alu_result = alu_in1 & alu_in2;
            3'd3:    alu_result = alu_in1 | alu_in2;
            default: alu_result = 'x;
        endcase
        alu_zero = (alu_result == 32'd0);
        alu_neg  = alu_result[31];
        alu_lt   = $signed(alu_in1) < $signed(alu_in2);
    end

    typedef struct {
        logic [3:0]  valid;
        logic [3:0]  lock;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        spread;     // requester i gets in1 = a + i*0x100
        logic [3:0]  exp_ready;
        logic [31:0] exp_res;
        logic [3:0]  exp_flags;  // {zero, neg, lt, err}
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [3:0] valid, lock, input logic [2:0] op,
                                input logic [31:0] a, b, input logic spread,
                                input logic [3:0] rdy, input logic [31:0] res,
                                input logic [3:0] flags);
        vec_t v;
        v.valid = valid; v.lock = lock; v.op = op; v.a = a; v.b = b; v.spread = spread;
        v.exp_ready = rdy; v.exp_res = res; v.exp_flags = flags;
        return v;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] valid, lock, input logic [2:0] op,
                         input logic [31:0] a, b, input logic spread);
        bus.req_valid = valid;
        bus.req_lock  = lock;
        for (int i = 0; i < 4; i++) begin
            bus.req_in1[i*32 +: 32] = spread ? a + 32'(i) * 32'h100 : a;
            bus.req_in2[i*32 +: 32] = b;
            bus.req_op[i*3 +: 3]    = op;
        end
    endtask

    task automatic chk_rsp(input string name, input logic [3:0] rv, input logic [31:0] res,
                           input logic [3:0] flags);
        chk({name, " rsp_valid"}, 128'(bus.rsp_valid), 128'(rv));
        chk({name, " rsp_result"}, 128'(bus.rsp_result), 128'(res));
        chk({name, " rsp_flags"}, 128'({bus.rsp_zero, bus.rsp_neg, bus.rsp_lt, bus.rsp_err}),
            128'(flags));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs.push_back(mk(4'b0001, 4'b0000, ADD, 32'd5, 32'd7, 1'b0, 4'b0001, 32'd12, 4'b0010));
        vecs.push_back(mk(4'b1111, 4'b0000, ADD, 32'd0, 32'd0, 1'b1, 4'b0010, 32'h100, 4'b0000));
        vecs.push_back(mk(4'b1111, 4'b0000, ADD, 32'd0, 32'd0, 1'b1, 4'b0100, 32'h200, 4'b0000));
        vecs.push_back(mk(4'b1111, 4'b0000, ADD, 32'd0, 32'd0, 1'b1, 4'b1000, 32'h300, 4'b0000));
        vecs.push_back(mk(4'b1111, 4'b0000, ADD, 32'd0, 32'd0, 1'b1, 4'b0001, 32'h0, 4'b1000));
        vecs.push_back(mk(4'b0100, 4'b0000, SUB, 32'd3, 32'd3, 1'b0, 4'b0100, 32'h0, 4'b1000));
        vecs.push_back(mk(4'b0100, 4'b0000, SUB, 32'd1, 32'd2, 1'b0, 4'b0100, 32'hFFFF_FFFF, 4'b0110));
        vecs.push_back(mk(4'b0000, 4'b0000, ADD, 32'd0, 32'd0, 1'b0, 4'b0000, 32'hFFFF_FFFF, 4'b0110));
        vecs.push_back(mk(4'b0001, 4'b0000, AND, 32'hF0F0, 32'hFF00, 1'b0, 4'b0001, 32'hF000, 4'b0010));
        // Requester 1 holds lock: four grants, forced release to 2, then 3, 0, and re-lock.
        for (int k = 0; k < 4; k++)
            vecs.push_back(mk(4'b1111, 4'b0010, OR, 32'h0F, 32'h30, 1'b0, 4'b0010, 32'h3F, 4'b0010));
        vecs.push_back(mk(4'b1111, 4'b0010, OR, 32'h0F, 32'h30, 1'b0, 4'b0100, 32'h3F, 4'b0010));
        vecs.push_back(mk(4'b1111, 4'b0010, OR, 32'h0F, 32'h30, 1'b0, 4'b1000, 32'h3F, 4'b0010));
        vecs.push_back(mk(4'b1111, 4'b0010, OR, 32'h0F, 32'h30, 1'b0, 4'b0001, 32'h3F, 4'b0010));
        vecs.push_back(mk(4'b1111, 4'b0010, OR, 32'h0F, 32'h30, 1'b0, 4'b0010, 32'h3F, 4'b0010));
        vecs.push_back(mk(4'b1111, 4'b0010, OR, 32'h0F, 32'h30, 1'b0, 4'b0010, 32'h3F, 4'b0010));
        vecs.push_back(mk(4'b1101, 4'b0010, OR, 32'h0F, 32'h30, 1'b0, 4'b0100, 32'h3F, 4'b0010));
        vecs.push_back(mk(4'b0001, 4'b0000, ADD, 32'd1, 32'd1, 1'b0, 4'b0001, 32'd2, 4'b0000));

        rst_n = 1'b0;
        drive(4'b0000, 4'b0000, ADD, 32'd0, 32'd0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk_rsp("reset", 4'b0000, 32'd0, 4'b0000);
        chk("reset ready", 128'(bus.req_ready), 128'(4'b0000));
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[k]) begin
            @(negedge clk);
            drive(vecs[k].valid, vecs[k].lock, vecs[k].op, vecs[k].a, vecs[k].b, vecs[k].spread);
            #1;
            chk($sformatf("v%0d ready", k), 128'(bus.req_ready), 128'(vecs[k].exp_ready));
            if (vecs[k].exp_ready == 4'b0000)
                chk($sformatf("v%0d idle alu", k), 128'({alu_op, alu_in1, alu_in2}), 128'(0));
            @(posedge clk);
            #1;
            chk_rsp($sformatf("v%0d", k), vecs[k].exp_ready, vecs[k].exp_res, vecs[k].exp_flags);
        end

        // Illegal op from requester 3 (pointer is at 1).
        @(negedge clk);
        drive(4'b1000, 4'b0000, 3'd6, 32'hDEAD_BEEF, 32'h1234_5678, 1'b0);
        #1;
        chk("illegal ready", 128'(bus.req_ready), 128'(4'b1000));
        chk("illegal alu", 128'({alu_op, alu_in1, alu_in2}), 128'(0));
        @(posedge clk);
        #1;
        chk_rsp("illegal", 4'b1000, 32'd0, 4'b0001);
        chk("illegal no x", 128'($isunknown({bus.rsp_valid, bus.rsp_result, bus.rsp_zero,
            bus.rsp_neg, bus.rsp_lt, bus.rsp_err})), 128'(0));
        @(negedge clk);
        drive(4'b0001, 4'b0000, ADD, 32'd1, 32'd1, 1'b0);
        @(posedge clk);
        #1;
        chk_rsp("err clear", 4'b0001, 32'd2, 4'b0000);

        // Async reset while a response is showing and another grant is in flight.
        @(negedge clk);
        drive(4'b0010, 4'b0000, ADD, 32'd2, 32'd3, 1'b0);
        #1;
        chk("pre-reset ready", 128'(bus.req_ready), 128'(4'b0010));
        @(posedge clk);
        #1;
        chk_rsp("pre-reset", 4'b0010, 32'd5, 4'b0010);
        #2;
        rst_n = 1'b0;
        #1;
        chk("reset drop rsp_valid", 128'(bus.rsp_valid), 128'(4'b0000));
        chk("reset drop rsp_result", 128'(bus.rsp_result), 128'(0));
        drive(4'b0000, 4'b0000, ADD, 32'd0, 32'd0, 1'b0);
        repeat (2) begin
            @(posedge clk);
            #1;
            chk("in reset rsp_valid", 128'(bus.rsp_valid), 128'(4'b0000));
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post-reset rsp_valid", 128'(bus.rsp_valid), 128'(4'b0000));
        @(negedge clk);
        drive(4'b1111, 4'b0000, ADD, 32'd0, 32'd0, 1'b1);
        #1;
        chk("post-reset ready", 128'(bus.req_ready), 128'(4'b0001));
        @(posedge clk);
        #1;
        chk_rsp("post-reset", 4'b0001, 32'd0, 4'b1000);

        @(negedge clk);
        drive(4'b0000, 4'b0000, ADD, 32'd0, 32'd0, 1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
